// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//    Program counter and fetch stage sitting directly in front of a small
//    combinational instruction ROM. The PC drives the ROM address, the ROM
//    word is captured into an instruction register together with the PC it
//    came from, and the pair is offered downstream over a valid/ready
//    handshake. Supports redirects (branch/jump), backpressure stalls and a
//    halt opcode that stops fetching once it has been captured.
//
// Ports:
//    clk            in   rising-edge clock
//    rst_n          in   asynchronous active-low reset
//    start          in   level, leaves IDLE and begins fetching
//    imemAddr       out  ROM read address, always equal to the PC
//    imemData       in   ROM read data, valid in the same cycle
//    redirectValid  in   load PC from redirectAddr and flush the output
//    redirectAddr   in   redirect target
//    instrValid     out  instrOut/instrPc hold a valid instruction
//    instrReady     in   downstream accepts the instruction this cycle
//    instrOut       out  fetched instruction word
//    instrPc        out  address the instruction was fetched from
//    halted         out  high while in HALT
//
// Configuration:
//    IFU_WRAP_HALT_EN  when defined, a capture at the last ROM address also
//                      halts fetching (the PC still wraps to 0). When not
//                      defined the PC wraps silently and fetching continues.
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter int                ADDR_W      = 3,
   parameter int                INSTR_W     = 12,
   parameter int                OPC_W       = 4,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [OPC_W-1:0]  HALT_OPCODE = {OPC_W{1'b1}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  imemAddr,
   input  logic [INSTR_W-1:0] imemData,
   input  logic               redirectValid,
   input  logic [ADDR_W-1:0]  redirectAddr,
   output logic               instrValid,
   input  logic               instrReady,
   output logic [INSTR_W-1:0] instrOut,
   output logic [ADDR_W-1:0]  instrPc,
   output logic               halted
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HALT
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic                 instr_valid_q, instr_valid_d;
   logic [INSTR_W-1:0]   instr_out_q, instr_out_d;
   logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
   logic                 slot_free;
   logic                 halt_opcode_hit;
   logic                 wrap_halt_hit;

   // The output slot can take a new word when it is empty or when its
   // current occupant is being accepted in this very cycle; this is what
   // lets the stage sustain one instruction per cycle with ready held high.
   assign slot_free       = ~instr_valid_q | instrReady;
   assign halt_opcode_hit = (imemData[INSTR_W-1 -: OPC_W] == HALT_OPCODE);

   // The wrap-halt option only matters on a capture from the top address;
   // without the option this term is tied low so the PC wraps silently.
`ifdef IFU_WRAP_HALT_EN
   assign wrap_halt_hit = (pc_q == {ADDR_W{1'b1}});
`else
   assign wrap_halt_hit = 1'b0;
`endif

   // Next-state and datapath decisions. Everything holds by default, then
   // each state applies its rule with redirect taking priority over a
   // capture, and a capture taking priority over simply holding.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_valid_d = instr_valid_q;
      instr_out_d   = instr_out_q;
      instr_pc_d    = instr_pc_q;

      unique case (state_q)
         IDLE: begin
            if (redirectValid) begin
               pc_d = redirectAddr;
            end else if (start) begin
               state_d = FETCH;
            end
         end

         FETCH: begin
            if (redirectValid) begin
               pc_d          = redirectAddr;
               instr_valid_d = 1'b0;
            end else if (slot_free) begin
               instr_out_d   = imemData;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + 1'b1;
               if (halt_opcode_hit || wrap_halt_hit) begin
                  state_d = HALT;
               end
            end
         end

         HALT: begin
            if (redirectValid) begin
               pc_d          = redirectAddr;
               instr_valid_d = 1'b0;
               state_d       = FETCH;
            end else if (instrReady) begin
               instr_valid_d = 1'b0;
            end
         end

         default: begin
            state_d       = IDLE;
            instr_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers. Reset is asynchronous so the outputs
   // drop to their idle values immediately, even in the middle of a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_valid_q <= 1'b0;
         instr_out_q   <= '0;
         instr_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_valid_q <= instr_valid_d;
         instr_out_q   <= instr_out_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

   // The ROM address is the PC itself; halted is decoded from the state
   // register so it changes only on a clock edge or reset.
   assign imemAddr   = pc_q;
   assign instrValid = instr_valid_q;
   assign instrOut   = instr_out_q;
   assign instrPc    = instr_pc_q;
   assign halted     = (state_q == HALT);

endmodule
